debug_probe: RTL and testbench
==============================

Name: debug_probe

Overview:
- Host-side controller for the CPU single-step debug port. It drives debug_en, debug_step and debug_addr, and reads back the register file and the pipeline-stage PCs.
- Accepts simple commands: free-run, halt, single step and dump.
- On dump, serialises a fixed 149-byte snapshot frame onto a byte stream with valid/ready handshake, intended for a UART transmitter.
- Sits beside the CPU in the board top level, clocked by the board clock.

Parameters:
- SETTLE, 2: cycles debug_addr is held before debug_REG is sampled (min 1).
- STEP_HIGH, 4: cycles debug_step is held high, and then held low, per step (min 1).

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  probe can accept a command; high only in IDLE.
- cmd_op  in  2  00 FREE, 01 HALT, 10 STEP, 11 DUMP.
- debug_en  out  1  to CPU; 1 = CPU clocked by debug_step.
- debug_step  out  1  to CPU step clock; driven directly from a flop, glitch-free.
- debug_addr  out  7  to CPU; register index in bits [4:0]; bits [6:5] always 0.
- debug_data  in  32  CPU IF-stage instruction word.
- debug_REG  in  32  register file value at debug_addr.
- debug_ID, debug_EX, debug_ME, debug_WB  in  32 each  stage PCs; FFFFFFFF = bubble.
- out_valid  out  1  frame byte available.
- out_ready  in  1  sink accepts the byte.
- out_data  out  8  frame byte.
- out_last  out  1  high with the final byte of the frame.

Behaviour:
- Reset (async, immediate) values:
  - state IDLE, cmd_ready 1;
  - debug_en 0, debug_step 0, debug_addr 0;
  - out_valid 0, out_data 0, out_last 0;
  - all capture registers 0.
- Reset mid-frame aborts the frame with no out_last. Reset mid-step forces debug_step low.
- Command handshake:
  - A command is accepted in the cycle where cmd_valid && cmd_ready. The op is latched, cmd_ready drops the next cycle, and it returns high on re-entering IDLE.
- FREE / HALT:
  - debug_en becomes 0 / 1 at N+1, where N is the accept cycle; back to IDLE at N+1.
- STEP:
  - If debug_en = 0: no pulse; return to IDLE at N+1.
  - Else: STEP_HI state, debug_step = 1 for cycles N+1 .. N+STEP_HIGH. Then STEP_LO state, debug_step = 0 for STEP_HIGH cycles. Then IDLE, with cmd_ready high at N+1+2*STEP_HIGH.
- DUMP:
  - Allowed in either debug_en state. debug_en is never changed by DUMP.
  - Byte frame order:
    - byte 0 = 8'hA5;
    - bytes 1..128 = R0..R31, each 4 bytes, MSB first;
    - bytes 129..148 = debug_data, debug_ID, debug_EX, debug_ME, debug_WB, each MSB first.
    - out_last is high on byte 148 only.
  - At the accept edge, debug_data, debug_ID, debug_EX, debug_ME and debug_WB are captured together into snapshot registers. The pipe words emitted are this snapshot.
  - States:
    - HDR: present 8'hA5.
    - SET: debug_addr <= i.
    - SETTLE: wait SETTLE cycles, then latch debug_REG into a 32-bit shift word.
    - BYTES: emit 4 bytes.
    - After the BYTES for i = 31, go to PIPE; for i < 31, return to SET with i+1.
    - PIPE: emit the 20 snapshot bytes.
    - After byte 148 is accepted, return to IDLE.
  - debug_addr holds 31 after the dump completes.
  - The header is valid at N+1.
- Stream rules:
  - Each byte transfers on out_valid && out_ready.
  - While out_valid && !out_ready, out_data and out_last are held stable, and out_valid cannot drop.
  - out_valid is 0 during SET and SETTLE.
  - Back-to-back bytes within a word and within PIPE are permitted, one per cycle, with out_ready held high.
- Counters:
  - 5-bit register index, stops at 31 (no wrap).
  - 2-bit byte index within a word.
  - 3-bit pipe-word index, 0..4.
  - Settle and step counters sized for their parameters.
- Commands offered while cmd_ready = 0 are not accepted; the source holds them.

Test Plan:
- Reset, then HALT accepted at cycle N → debug_en = 1 at N+1; cmd_ready = 1 at N+1; debug_step stays 0.
- HALT, then STEP with STEP_HIGH = 4, accepted at N → debug_step high in cycles N+1..N+4 and low in N+5..N+8; cmd_ready = 1 at N+9; exactly one rising edge.
- FREE, then STEP → no debug_step pulse; cmd_ready = 1 one cycle after accept.
- CPU model with R[i] = 32'h1000_0000 + i, debug_ID = 32'h0000_0040, and out_ready tied to 1; DUMP →
  - 149 bytes: A5, 10 00 00 00, 10 00 00 01, … ;
  - R31 bytes = 10 00 00 1F;
  - bytes 133..136 = 00 00 00 40;
  - out_last on byte 148 only;
  - debug_addr sweeps 0..31.
- DUMP with out_ready toggling pseudo-randomly → byte sequence identical to the previous scenario; out_data stable during every stall; no dropped or duplicated bytes.
- Assert rst during byte 60 of a DUMP → out_valid = 0, debug_addr = 0, cmd_ready = 1 immediately. A new DUMP then emits a full frame starting with A5.

Source files
------------

// File: rtl/debug_probe.sv
// debug_probe: host-side controller for the CPU single-step debug port.
// Runs, halts or single-steps the CPU. On DUMP it streams a 149-byte frame
// (header, R0..R31, then the pipeline snapshot), one byte per valid/ready beat.
module debug_probe #(
  parameter int SETTLE    = 2,
  parameter int STEP_HIGH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  output logic        debug_en,
  output logic        debug_step,
  output logic [6:0]  debug_addr,
  input  logic [31:0] debug_data,
  input  logic [31:0] debug_REG,
  input  logic [31:0] debug_ID,
  input  logic [31:0] debug_EX,
  input  logic [31:0] debug_ME,
  input  logic [31:0] debug_WB,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int STP_W = (STEP_HIGH > 1) ? $clog2(STEP_HIGH) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [STP_W-1:0] STEP_LAST   = STP_W'(STEP_HIGH - 1);

  typedef enum logic [1:0] {
    OP_FREE = 2'b00,
    OP_HALT = 2'b01,
    OP_STEP = 2'b10,
    OP_DUMP = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STEP_HI,
    S_STEP_LO,
    S_HDR,
    S_SET,
    S_SETTLE,
    S_BYTES,
    S_PIPE
  } state_t;

  state_t            state;
  logic [STP_W-1:0]  step_cnt;
  logic [SET_W-1:0]  settle_cnt;
  logic [4:0]        reg_idx;
  logic [1:0]        byte_idx;
  logic [2:0]        pipe_idx;
  logic [31:0]       shift_word;
  logic [31:0]       snap_data;
  logic [31:0]       snap_id;
  logic [31:0]       snap_ex;
  logic [31:0]       snap_me;
  logic [31:0]       snap_wb;

  logic [1:0]        byte_idx_nxt;
  logic [2:0]        pipe_idx_nxt;
  logic [31:0]       pipe_word_nxt;
  logic [7:0]        pipe_byte_nxt;

  // Byte idx of a word, most significant byte first.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_of = word[31:24];
      2'd1:    byte_of = word[23:16];
      2'd2:    byte_of = word[15:8];
      default: byte_of = word[7:0];
    endcase
  endfunction

  // Next snapshot byte to present while walking the five pipeline words.
  always_comb begin
    byte_idx_nxt = byte_idx + 2'd1;
    pipe_idx_nxt = (byte_idx == 2'd3) ? pipe_idx + 3'd1 : pipe_idx;
    case (pipe_idx_nxt)
      3'd0:    pipe_word_nxt = snap_data;
      3'd1:    pipe_word_nxt = snap_id;
      3'd2:    pipe_word_nxt = snap_ex;
      3'd3:    pipe_word_nxt = snap_me;
      default: pipe_word_nxt = snap_wb;
    endcase
    pipe_byte_nxt = byte_of(pipe_word_nxt, byte_idx_nxt);
  end

  // Command FSM: run/halt control, step pulse generation and frame serialiser.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      debug_en   <= 1'b0;
      debug_step <= 1'b0;
      debug_addr <= 7'd0;
      out_valid  <= 1'b0;
      out_data   <= 8'h00;
      out_last   <= 1'b0;
      step_cnt   <= '0;
      settle_cnt <= '0;
      reg_idx    <= 5'd0;
      byte_idx   <= 2'd0;
      pipe_idx   <= 3'd0;
      shift_word <= 32'd0;
      snap_data  <= 32'd0;
      snap_id    <= 32'd0;
      snap_ex    <= 32'd0;
      snap_me    <= 32'd0;
      snap_wb    <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (op_t'(cmd_op))
              OP_FREE: debug_en <= 1'b0;
              OP_HALT: debug_en <= 1'b1;
              OP_STEP: begin
                if (debug_en) begin
                  state      <= S_STEP_HI;
                  cmd_ready  <= 1'b0;
                  debug_step <= 1'b1;
                  step_cnt   <= '0;
                end
              end
              default: begin
                state     <= S_HDR;
                cmd_ready <= 1'b0;
                out_valid <= 1'b1;
                out_data  <= 8'hA5;
                out_last  <= 1'b0;
                reg_idx   <= 5'd0;
                snap_data <= debug_data;
                snap_id   <= debug_ID;
                snap_ex   <= debug_EX;
                snap_me   <= debug_ME;
                snap_wb   <= debug_WB;
              end
            endcase
          end
        end

        S_STEP_HI: begin
          if (step_cnt == STEP_LAST) begin
            debug_step <= 1'b0;
            step_cnt   <= '0;
            state      <= S_STEP_LO;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end

        S_STEP_LO: begin
          if (step_cnt == STEP_LAST) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end

        S_HDR: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_SET;
          end
        end

        S_SET: begin
          debug_addr <= {2'b00, reg_idx};
          settle_cnt <= '0;
          state      <= S_SETTLE;
        end

        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            shift_word <= debug_REG;
            out_data   <= debug_REG[31:24];
            out_valid  <= 1'b1;
            byte_idx   <= 2'd0;
            state      <= S_BYTES;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        S_BYTES: begin
          if (out_ready) begin
            if (byte_idx == 2'd3) begin
              if (reg_idx == 5'd31) begin
                state    <= S_PIPE;
                out_data <= snap_data[31:24];
                pipe_idx <= 3'd0;
                byte_idx <= 2'd0;
              end else begin
                out_valid <= 1'b0;
                reg_idx   <= reg_idx + 5'd1;
                state     <= S_SET;
              end
            end else begin
              byte_idx   <= byte_idx + 2'd1;
              shift_word <= {shift_word[23:0], shift_word[31:24]};
              out_data   <= shift_word[23:16];
            end
          end
        end

        S_PIPE: begin
          if (out_ready) begin
            if (pipe_idx == 3'd4 && byte_idx == 2'd3) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= S_IDLE;
              cmd_ready <= 1'b1;
            end else begin
              byte_idx <= byte_idx_nxt;
              pipe_idx <= pipe_idx_nxt;
              out_data <= pipe_byte_nxt;
              out_last <= (pipe_idx_nxt == 3'd4) && (byte_idx_nxt == 2'd3);
            end
          end
        end

        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_probe.sv
// tb_debug_probe: randomized self-checking bench for debug_probe.
// A small CPU model answers debug_REG from a register array; expected frames
// are built from that array and the pipeline words present at command accept.
module tb_debug_probe;

  localparam int SETTLE    = 2;
  localparam int STEP_HIGH = 4;
  localparam int FRAME_LEN = 149;

  localparam logic [1:0] OP_FREE = 2'b00;
  localparam logic [1:0] OP_HALT = 2'b01;
  localparam logic [1:0] OP_STEP = 2'b10;
  localparam logic [1:0] OP_DUMP = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic        debug_en;
  logic        debug_step;
  logic [6:0]  debug_addr;
  logic [31:0] debug_data;
  logic [31:0] debug_REG;
  logic [31:0] debug_ID;
  logic [31:0] debug_EX;
  logic [31:0] debug_ME;
  logic [31:0] debug_WB;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  logic [31:0] regs [32];
  logic [7:0]  exp_frame [$];
  logic [7:0]  got_frame [$];
  bit          got_last  [$];
  logic [4:0]  addr_seq  [$];

  int checks = 0;
  int fails  = 0;

  debug_probe #(.SETTLE(SETTLE), .STEP_HIGH(STEP_HIGH)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .debug_en   (debug_en),
    .debug_step (debug_step),
    .debug_addr (debug_addr),
    .debug_data (debug_data),
    .debug_REG  (debug_REG),
    .debug_ID   (debug_ID),
    .debug_EX   (debug_EX),
    .debug_ME   (debug_ME),
    .debug_WB   (debug_WB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last)
  );

  // CPU register file as seen through the debug port.
  assign debug_REG = regs[debug_addr[4:0]];

  always #5 clk = ~clk;

  // Safety net so a wedged design still ends the run.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offers a command at a falling edge and waits for its accept; returns at the
  // falling edge of the cycle after the accept edge (cycle N+1).
  task automatic applyStimulus(input logic [1:0] op);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    while (!cmd_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cmd_accept_wait", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Reference frame: header, each register MSB first, then the snapshot words.
  task automatic buildFrame(input logic [31:0] p_data, input logic [31:0] p_id,
                            input logic [31:0] p_ex, input logic [31:0] p_me,
                            input logic [31:0] p_wb);
    logic [31:0] pipe [5];
    pipe[0] = p_data; pipe[1] = p_id; pipe[2] = p_ex; pipe[3] = p_me; pipe[4] = p_wb;
    exp_frame.delete();
    exp_frame.push_back(8'hA5);
    for (int r = 0; r < 32; r++)
      for (int b = 3; b >= 0; b--)
        exp_frame.push_back(regs[r][8*b +: 8]);
    for (int w = 0; w < 5; w++)
      for (int b = 3; b >= 0; b--)
        exp_frame.push_back(pipe[w][8*b +: 8]);
  endtask

  // Issues a DUMP, collects the frame and compares it with the reference.
  // abort_at >= 0 pulses reset while that byte index is being presented.
  task automatic runDump(input bit rand_ready, input int abort_at);
    logic [31:0] p_data, p_id, p_ex, p_me, p_wb;
    logic        en_before;
    bit          done = 0;
    bit          stalled = 0;
    logic [7:0]  prev_data = 8'h00;
    logic        prev_last = 1'b0;
    int          cycles = 0;

    p_data = debug_data; p_id = debug_ID; p_ex = debug_EX;
    p_me = debug_ME; p_wb = debug_WB;
    en_before = debug_en;
    buildFrame(p_data, p_id, p_ex, p_me, p_wb);
    got_frame.delete();
    got_last.delete();
    addr_seq.delete();
    out_ready = 1'b0;

    applyStimulus(OP_DUMP);
    // Pipeline moves on after the accept; the frame must carry the snapshot.
    debug_data = $urandom; debug_ID = $urandom; debug_EX = $urandom;
    debug_ME = $urandom; debug_WB = $urandom;

    checkOutput("hdr_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("hdr_data", {24'd0, out_data}, 32'hA5);
    checkOutput("busy_ready", {31'd0, cmd_ready}, 32'd0);
    addr_seq.push_back(debug_addr[4:0]);

    while (!done && cycles < 5000) begin
      if (stalled) begin
        checkOutput("stall_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stall_data", {24'd0, out_data}, {24'd0, prev_data});
        checkOutput("stall_last", {31'd0, out_last}, {31'd0, prev_last});
      end
      if (debug_addr[4:0] != addr_seq[$]) addr_seq.push_back(debug_addr[4:0]);
      if (abort_at >= 0 && got_frame.size() == abort_at && out_valid) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_addr", {25'd0, debug_addr}, 32'd0);
        checkOutput("abort_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("abort_last", {31'd0, out_last}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        return;
      end
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        got_frame.push_back(out_data);
        got_last.push_back(out_last);
        if (out_last || got_frame.size() > FRAME_LEN) done = 1;
      end
      stalled   = out_valid && !out_ready;
      prev_data = out_data;
      prev_last = out_last;
      @(negedge clk);
      cycles++;
    end
    out_ready = 1'b0;

    checkOutput("frame_done", {31'd0, done}, 32'd1);
    checkOutput("frame_len", got_frame.size(), FRAME_LEN);
    for (int i = 0; i < got_frame.size() && i < FRAME_LEN; i++) begin
      checkOutput($sformatf("byte%0d", i), {24'd0, got_frame[i]}, {24'd0, exp_frame[i]});
      checkOutput($sformatf("last%0d", i), {31'd0, got_last[i]}, {31'd0, (i == FRAME_LEN - 1)});
    end
    checkOutput("end_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("end_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("end_addr", {25'd0, debug_addr}, 32'd31);
    checkOutput("en_kept", {31'd0, debug_en}, {31'd0, en_before});
    checkOutput("addr_seq_len", {31'd0, addr_seq.size() >= 32}, 32'd1);
    if (addr_seq.size() >= 32)
      for (int i = 0; i < 32; i++)
        checkOutput($sformatf("addr_sweep%0d", i),
                    {27'd0, addr_seq[addr_seq.size() - 32 + i]}, i);
  endtask

  task automatic loadPattern();
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + i;
    debug_data = 32'hDEAD_BEEF;
    debug_ID   = 32'h0000_0040;
    debug_EX   = 32'h0000_003C;
    debug_ME   = 32'h0000_0038;
    debug_WB   = 32'hFFFF_FFFF;
  endtask

  // Main sequence: reset, run control, stepping, dumps and a reset mid-frame.
  initial begin
    int rises;
    logic prev_step;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; out_ready = 1'b0;
    loadPattern();
    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("rst_debug_en", {31'd0, debug_en}, 32'd0);
    checkOutput("rst_debug_step", {31'd0, debug_step}, 32'd0);
    checkOutput("rst_debug_addr", {25'd0, debug_addr}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_data", {24'd0, out_data}, 32'd0);
    checkOutput("rst_out_last", {31'd0, out_last}, 32'd0);
    rst = 1'b0;

    applyStimulus(OP_HALT);
    checkOutput("halt_en", {31'd0, debug_en}, 32'd1);
    checkOutput("halt_ready", {31'd0, cmd_ready}, 32'd1);
    checkOutput("halt_step", {31'd0, debug_step}, 32'd0);

    applyStimulus(OP_STEP);
    rises = 0;
    prev_step = 1'b0;
    for (int k = 1; k <= 2 * STEP_HIGH + 1; k++) begin
      checkOutput($sformatf("step_level_k%0d", k), {31'd0, debug_step}, {31'd0, (k <= STEP_HIGH)});
      checkOutput($sformatf("step_ready_k%0d", k), {31'd0, cmd_ready}, {31'd0, (k == 2 * STEP_HIGH + 1)});
      if (debug_step && !prev_step) rises++;
      prev_step = debug_step;
      if (k < 2 * STEP_HIGH + 1) @(negedge clk);
    end
    checkOutput("step_rises", rises, 1);

    applyStimulus(OP_FREE);
    checkOutput("free_en", {31'd0, debug_en}, 32'd0);
    checkOutput("free_ready", {31'd0, cmd_ready}, 32'd1);
    applyStimulus(OP_STEP);
    checkOutput("free_step_ready", {31'd0, cmd_ready}, 32'd1);
    rises = 0;
    for (int k = 0; k < 2 * STEP_HIGH; k++) begin
      if (debug_step) rises++;
      @(negedge clk);
    end
    checkOutput("free_step_pulses", rises, 0);

    $display("[TB] dump with fixed pattern, sink always ready");
    runDump(1'b0, -1);

    $display("[TB] dump with fixed pattern, halted, sink stalling");
    applyStimulus(OP_HALT);
    loadPattern();
    runDump(1'b1, -1);

    $display("[TB] dumps with random register and pipeline contents");
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      debug_data = $urandom; debug_ID = $urandom; debug_EX = $urandom;
      debug_ME = $urandom; debug_WB = $urandom;
      runDump(1'b1, -1);
    end

    $display("[TB] reset while byte 60 is presented, then a fresh dump");
    loadPattern();
    runDump(1'b0, 60);
    checkOutput("post_abort_en", {31'd0, debug_en}, 32'd0);
    loadPattern();
    runDump(1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
